// File: rtl/regfile_pkg.sv
// Shared constants and bus-slicing helpers for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;

   // LSB position of port `port` in a flattened bus of `width`-bit fields
   function automatic int port_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback side bus of the register file: reads, writes, reservations, scoreboard.
interface regfile_mp_sb_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic [DEPTH-1:0]         busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reservation sets, writeback clears, set wins on collision.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rsv_en,
   input  logic [ADDR_W-1:0]    i_rsv_addr,
   input  logic                 i_clr_en,
   input  logic [ADDR_W-1:0]    i_clr_addr,
   output logic [2**ADDR_W-1:0] o_busy_vec
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_rsv_en && (i_rsv_addr == ADDR_W'(i)))
            w_busy_nxt[i] = 1'b1;
         else if (i_clr_en && (i_clr_addr == ADDR_W'(i)))
            w_busy_nxt[i] = 1'b0;
      end
      if (ZERO_REG)
         w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   regfile_mp_sb_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]        r_mem [DEPTH];
   logic [DEPTH-1:0]         w_busy_vec;
   logic [NUM_RD*DATA_W-1:0] w_rd_data;
   logic [NUM_RD-1:0]        w_rd_busy;
   logic                     w_wr_drop;

   assign w_wr_drop = ZERO_REG && (bus.wr_addr == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (bus.wr_en && !w_wr_drop) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rsv_en   (bus.rsv_en),
      .i_rsv_addr (bus.rsv_addr),
      .i_clr_en   (bus.wr_en),
      .i_clr_addr (bus.wr_addr),
      .o_busy_vec (w_busy_vec)
   );

   // A write under reset never lands, so neither bypass nor stored data is visible then
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_is_zero;
      logic              w_hit_wr;
      logic [DATA_W-1:0] w_data;

      assign w_addr    = bus.rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
      assign w_is_zero = ZERO_REG && (w_addr == '0);
      assign w_hit_wr  = bus.wr_en && (bus.wr_addr == w_addr);

      always_comb begin
         w_data = r_mem[w_addr];
         if (i_rst || w_is_zero)
            w_data = '0;
         else if (w_hit_wr)
            w_data = bus.wr_data;
      end

      assign w_rd_data[port_lsb(k, DATA_W) +: DATA_W] = w_data;
      assign w_rd_busy[k] = !i_rst && w_busy_vec[w_addr] && !w_hit_wr;
   end

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_busy  = w_rd_busy;
   assign bus.busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed vector table plus hand sequences and a model-based random run for regfile_mp_sb.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus_a ();
   regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) bus_b ();

   regfile_mp_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1'b1)) dut_a (
      .i_clk (clk),
      .i_rst (rst_a),
      .bus   (bus_a)
   );

   regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b0)) dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (bus_b)
   );

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [31:0] wr_data;
      logic        rsv_en;
      logic [3:0]  rsv_addr;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        eb0;
      logic        eb1;
      logic [15:0] ebv;
   } vec_t;

   vec_t tv [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] m_mem [8];
   logic [7:0]  m_busy;
   logic        r_we, r_re;
   logic [2:0]  r_wa, r_ra;
   logic [15:0] r_wd;
   logic [2:0]  r_rda [4];

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.rd_addr = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_a.rsv_en = 1'b0; bus_a.rsv_addr = '0;
      bus_b.rd_addr = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
      bus_b.rsv_en = 1'b0; bus_b.rsv_addr = '0;

      //        we   wa     wd             re   ra     ra0    ra1    e0             e1             eb0   eb1   busy_vec
      tv[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 16'h0000};
      tv[1]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd3, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000};
      tv[2]  = '{1'b1, 4'd0, 32'h12345678, 1'b1, 4'd0, 4'd0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b0, 16'h0000};
      tv[3]  = '{1'b1, 4'd5, 32'h00000001, 1'b0, 4'd0, 4'd0, 4'd5, 32'h0,        32'h00000001, 1'b0, 1'b0, 16'h0000};
      tv[4]  = '{1'b1, 4'd5, 32'hA5A5A5A5, 1'b0, 4'd0, 4'd3, 4'd5, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b0, 1'b0, 16'h0000};
      tv[5]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 4'd5, 4'd7, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 16'h0000};
      tv[6]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd7, 4'd5, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0, 16'h0080};
      tv[7]  = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 4'd7, 4'd7, 32'h0,        32'h0,        1'b1, 1'b1, 16'h0080};
      tv[8]  = '{1'b1, 4'd7, 32'h00000077, 1'b0, 4'd0, 4'd7, 4'd3, 32'h00000077, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0080};
      tv[9]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd7, 4'd7, 32'h00000077, 32'h00000077, 1'b0, 1'b0, 16'h0000};
      tv[10] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd9, 4'd9, 4'd9, 32'h0,        32'h0,        1'b0, 1'b0, 16'h0000};
      tv[11] = '{1'b1, 4'd9, 32'h00000099, 1'b1, 4'd9, 4'd9, 4'd0, 32'h00000099, 32'h0,        1'b0, 1'b0, 16'h0200};
      tv[12] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd9, 4'd9, 32'h00000099, 32'h00000099, 1'b1, 1'b1, 16'h0200};
      tv[13] = '{1'b1, 4'd2, 32'hCAFEF00D, 1'b1, 4'd15,4'd9, 4'd2, 32'h00000099, 32'hCAFEF00D, 1'b1, 1'b0, 16'h0200};
      tv[14] = '{1'b1, 4'd9, 32'h0000ABCD, 1'b0, 4'd0, 4'd15,4'd9, 32'h0,        32'h0000ABCD, 1'b1, 1'b0, 16'h8200};
      tv[15] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd9, 4'd2, 32'h0000ABCD, 32'hCAFEF00D, 1'b0, 1'b0, 16'h8000};

      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("reset busy_vec a", 64'(bus_a.busy_vec), 64'h0);
      chk("reset rd_data a", 64'(bus_a.rd_data), 64'h0);

      for (int i = 0; i < 16; i++) begin
         bus_a.wr_en    = tv[i].wr_en;
         bus_a.wr_addr  = tv[i].wr_addr;
         bus_a.wr_data  = tv[i].wr_data;
         bus_a.rsv_en   = tv[i].rsv_en;
         bus_a.rsv_addr = tv[i].rsv_addr;
         bus_a.rd_addr  = {tv[i].ra1, tv[i].ra0};
         #1;
         chk($sformatf("vec%0d rd0", i), 64'(bus_a.rd_data[31:0]), 64'(tv[i].e0));
         chk($sformatf("vec%0d rd1", i), 64'(bus_a.rd_data[63:32]), 64'(tv[i].e1));
         chk($sformatf("vec%0d busy0", i), 64'(bus_a.rd_busy[0]), 64'(tv[i].eb0));
         chk($sformatf("vec%0d busy1", i), 64'(bus_a.rd_busy[1]), 64'(tv[i].eb1));
         chk($sformatf("vec%0d busy_vec", i), 64'(bus_a.busy_vec), 64'(tv[i].ebv));
         tick();
      end

      // reset wins over a simultaneous write and reservation; reg15 is busy going in
      rst_a = 1'b1;
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd4; bus_a.wr_data = 32'h11111111;
      bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 4'd4;
      bus_a.rd_addr = {4'd15, 4'd3};
      #1;
      chk("in-reset rd_data", 64'(bus_a.rd_data), 64'h0);
      chk("in-reset rd_busy", 64'(bus_a.rd_busy), 64'h0);
      tick();
      rst_a = 1'b0;
      bus_a.wr_en = 1'b0; bus_a.rsv_en = 1'b0;
      bus_a.rd_addr = {4'd4, 4'd3};
      #1;
      chk("post-reset reg3", 64'(bus_a.rd_data[31:0]), 64'h0);
      chk("post-reset reg4", 64'(bus_a.rd_data[63:32]), 64'h0);
      chk("post-reset busy_vec", 64'(bus_a.busy_vec), 64'h0);

      // four ports, duplicate address
      bus_b.wr_en = 1'b1;
      bus_b.wr_addr = 3'd1; bus_b.wr_data = 16'h0011; tick();
      bus_b.wr_addr = 3'd2; bus_b.wr_data = 16'h0022; tick();
      bus_b.wr_addr = 3'd7; bus_b.wr_data = 16'h0077; tick();
      bus_b.wr_en = 1'b0;
      bus_b.rd_addr = {3'd7, 3'd2, 3'd1, 3'd1};
      #1;
      chk("mp port0", 64'(bus_b.rd_data[15:0]),  64'h0011);
      chk("mp port1", 64'(bus_b.rd_data[31:16]), 64'h0011);
      chk("mp port2", 64'(bus_b.rd_data[47:32]), 64'h0022);
      chk("mp port3", 64'(bus_b.rd_data[63:48]), 64'h0077);

      // register 0 is ordinary when ZERO_REG=0
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 3'd0; bus_b.wr_data = 16'h00AA;
      bus_b.rsv_en = 1'b1; bus_b.rsv_addr = 3'd0;
      bus_b.rd_addr = {3'd0, 3'd0, 3'd0, 3'd0};
      #1;
      chk("r0 bypass", 64'(bus_b.rd_data[15:0]), 64'h00AA);
      tick();
      bus_b.wr_en = 1'b0; bus_b.rsv_en = 1'b0;
      #1;
      chk("r0 stored", 64'(bus_b.rd_data[63:48]), 64'h00AA);
      chk("r0 rd_busy", 64'(bus_b.rd_busy), 64'hF);
      chk("r0 busy_vec", 64'(bus_b.busy_vec), 64'h01);

      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_busy = '0;

      for (int c = 0; c < 300; c++) begin
         r_we = 1'($urandom_range(0, 1));
         r_re = 1'($urandom_range(0, 3) == 0);
         r_wa = 3'($urandom_range(0, 7));
         r_ra = 3'($urandom_range(0, 7));
         r_wd = 16'($urandom);
         for (int k = 0; k < 4; k++) r_rda[k] = 3'($urandom_range(0, 7));
         bus_b.wr_en = r_we; bus_b.wr_addr = r_wa; bus_b.wr_data = r_wd;
         bus_b.rsv_en = r_re; bus_b.rsv_addr = r_ra;
         bus_b.rd_addr = {r_rda[3], r_rda[2], r_rda[1], r_rda[0]};
         #1;
         for (int k = 0; k < 4; k++) begin
            logic [15:0] ed;
            logic        eb;
            ed = (r_we && r_wa == r_rda[k]) ? r_wd : m_mem[r_rda[k]];
            eb = m_busy[r_rda[k]] && !(r_we && r_wa == r_rda[k]);
            chk($sformatf("rand%0d data%0d", c, k), 64'(bus_b.rd_data[k*16 +: 16]), 64'(ed));
            chk($sformatf("rand%0d busy%0d", c, k), 64'(bus_b.rd_busy[k]), 64'(eb));
         end
         chk($sformatf("rand%0d busy_vec", c), 64'(bus_b.busy_vec), 64'(m_busy));
         tick();
         if (r_we) begin
            m_mem[r_wa] = r_wd;
            m_busy[r_wa] = 1'b0;
         end
         if (r_re) m_busy[r_ra] = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the CPU register file.
- Width, depth and read-port count are configurable.
- Adds a write enable, an optional hardwired zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode (reads, reservations) and writeback; the pipeline uses the rd_busy flags to stall on outstanding multi-cycle results.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/reservations; 0 = register 0 is ordinary

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = register on port k has an outstanding reservation not satisfied this cycle
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe: mark rsv_addr as pending a future write
- rsv_addr  in  ADDR_W  register to reserve
- busy_vec  out  2**ADDR_W  current scoreboard state (registered), for debug/hazard unit

Behaviour:
- Reset: when rst=1 at a rising edge, all registers become 0 and busy_vec becomes 0.
  - rst has priority over wr_en and rsv_en in the same cycle.
  - Outputs during reset are combinational from the cleared state: rd_data=0, rd_busy=0.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, 0-cycle latency), per port k, priority order:
  1. ZERO_REG=1 and rd_addr_k=0 -> 0.
  2. wr_en=1 and wr_addr=rd_addr_k (bypass) -> wr_data.
  3. Otherwise -> reg[rd_addr_k].
  - Multiple ports may read the same address; each resolves independently.
- Scoreboard, next state of busy[i]:
  - Set if rsv_en=1 and rsv_addr=i.
  - Else cleared if wr_en=1 and wr_addr=i.
  - Else held.
  - Simultaneous reserve and write to the same address: the set wins (the write lands; the new reservation stays pending).
  - If ZERO_REG=1, busy[0] is constant 0; reserving register 0 is ignored.
  - Reserving an already-busy register keeps it busy (no count, no error).
  - Writing a non-busy register is a legal plain write.
- rd_busy_k = busy[rd_addr_k] AND NOT (wr_en AND wr_addr=rd_addr_k).
  - The bypass satisfies the hazard in the writeback cycle.
  - rd_busy_k is 0 for address 0 when ZERO_REG=1.
- A same-cycle reservation does not affect rd_busy until the following cycle.
- No X propagation: every storage element is reset; addresses are always in range because depth = 2**ADDR_W.

Decomposition:
- Shared package regfile_pkg:
  - Default constants DATA_W_DEF=32 and ADDR_W_DEF=4.
  - Function port_slice helpers for the flattened rd_addr/rd_data buses.
- One natural sub-module, regfile_scoreboard:
  - Owns the busy bits, the set/clear priority and the ZERO_REG masking.
  - Ports: clk, rst, rsv_en, rsv_addr, clr_en, clr_addr, busy_vec.
- Storage, bypass and read muxes stay in the top level.

Test Plan:
- Reset: load reg3=0xDEADBEEF, then hold rst=1 for 1 cycle -> reading reg3 gives 0x00000000, busy_vec=0.
- Zero register (ZERO_REG=1): write 0x12345678 to reg0, then read port0 addr 0 -> 0; set rsv_en on reg0 -> busy_vec[0] stays 0.
- Bypass: reg5=0x1; in the same cycle wr_en=1, wr_addr=5, wr_data=0xA5A5A5A5, rd_addr port1=5 -> rd_data port1=0xA5A5A5A5 that cycle; the next cycle also reads 0xA5A5A5A5.
- Scoreboard life cycle:
  - Reserve reg7 in cycle N -> rd_busy=1 from N+1.
  - Writeback reg7=0x77 in cycle N+3 -> rd_busy=0 and rd_data=0x77 in cycle N+3; busy_vec[7]=0 in N+4.
- Set/clear collision: reg9 busy; the same cycle has rsv_en and wr_en on reg9 with data 0x99 -> next cycle reg9=0x99 and busy_vec[9]=1.
- Multi-port with NUM_RD=4, DATA_W=16, ADDR_W=3: four ports read addresses 1,1,2,7 holding 0x0011, 0x0022, 0x0077 -> outputs 0x0011, 0x0011, 0x0022, 0x0077; plus a random write/reserve/read regression against a reference model.
